// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: widths, accelerator-load encoding and burst FSM types for the fetch stage.
package if_fetch_unit_pkg;
  localparam int DATA_BITS = 64;
  localparam int WORD_BITS = 32;
  localparam int ACC_LEN_BITS = 12;
  localparam logic [6:0] ACC_OPCODE = 7'h0B;
  typedef enum logic [2:0] {
    ACC_TGT_NTT    = 3'd0,
    ACC_TGT_PWAM_A = 3'd1,
    ACC_TGT_PWAM_B = 3'd2,
    ACC_TGT_KECCAK = 3'd3
  } acc_tgt_e;
  typedef enum logic {IDLE, BURST} burst_state_e;
  typedef struct packed {
    logic keccak;
    logic pwam_b;
    logic pwam_a;
    logic ntt;
  } acc_we_t;
  // Targets 4-7 select no accelerator.
  function automatic acc_we_t tgt_we(input logic [2:0] tgt);
    return tgt[2] ? acc_we_t'(4'b0000) : acc_we_t'(4'b0001 << tgt[1:0]);
  endfunction
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: control, ROM and reg_if_id signals of the fetch stage.
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;
  logic                 CE;
  logic                 stall;
  logic                 redirect_valid;
  logic [DATA_BITS-1:0] redirect_pc;
  logic [DATA_BITS-1:0] imem_addr;
  logic [WORD_BITS-1:0] imem_rdata;
  logic [WORD_BITS-1:0] inst_out;
  logic [DATA_BITS-1:0] pc_out;
  logic                 ntt_we;
  logic                 pwam_wea;
  logic                 pwam_web;
  logic                 keccak_we;
  logic [DATA_BITS-1:0] counter;
  logic                 busy;
  modport master (
    input  CE, stall, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, inst_out, pc_out, ntt_we, pwam_wea, pwam_web, keccak_we, counter, busy
  );
  modport slave (
    output CE, stall, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, inst_out, pc_out, ntt_we, pwam_wea, pwam_web, keccak_we, counter, busy
  );
endinterface

// File: rtl/if_fetch_unit_acc_burst_seq.sv
// if_fetch_unit_acc_burst_seq: accelerator-load burst FSM and beat counter.
module if_fetch_unit_acc_burst_seq
  import if_fetch_unit_pkg::*;
#(
  parameter int LEN_BITS = ACC_LEN_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                advance_i,
  input  logic                flush_i,
  input  logic                is_burst_i,
  input  logic [LEN_BITS-1:0] len_i,
  output logic [LEN_BITS-1:0] beat_o,
  output logic                busy_o,
  output logic                pc_inc_o
);
  burst_state_e        state_q;
  logic [LEN_BITS-1:0] beat_q;
  logic                last_beat;
  assign last_beat = (beat_q + LEN_BITS'(1)) >= len_i;
  assign pc_inc_o  = advance_i & (state_q == BURST ? last_beat : (~is_burst_i | len_i == LEN_BITS'(1)));
  assign beat_o    = beat_q;
  assign busy_o    = state_q == BURST;
  // An advance that does not retire the instruction can only mean the next beat of a burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else if (flush_i || pc_inc_o) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else if (advance_i) begin
      state_q <= BURST;
      beat_q  <= beat_q + LEN_BITS'(1);
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: RISCV64 fetch stage; owns the PC and expands accelerator loads into beats.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [DATA_BITS-1:0] RESET_PC      = '0,
  parameter logic [6:0]           CUSTOM_OPCODE = ACC_OPCODE,
  parameter int                   LEN_BITS      = ACC_LEN_BITS
) (
  input logic            clk,
  input logic            rst,
  if_fetch_unit_if.master bus
);
  logic [DATA_BITS-1:0] pc_q;
  logic [DATA_BITS-1:0] pc_d;
  logic [LEN_BITS-1:0]  len;
  logic [LEN_BITS-1:0]  beat;
  logic [2:0]           tgt;
  logic                 advance;
  logic                 flush;
  logic                 is_burst;
  logic                 busy;
  logic                 pc_inc;
  acc_we_t              we;
  assign advance  = bus.CE & ~bus.stall & ~bus.redirect_valid;
  assign flush    = bus.CE & bus.redirect_valid;
  assign tgt      = bus.imem_rdata[14:12];
  assign len      = bus.imem_rdata[31 -: LEN_BITS];
  assign is_burst = bus.imem_rdata[6:0] == CUSTOM_OPCODE && !tgt[2] && len != '0;
  if_fetch_unit_acc_burst_seq #(.LEN_BITS(LEN_BITS)) u_seq (
    .clk       (clk),
    .rst       (rst),
    .advance_i (advance),
    .flush_i   (flush),
    .is_burst_i(is_burst),
    .len_i     (len),
    .beat_o    (beat),
    .busy_o    (busy),
    .pc_inc_o  (pc_inc)
  );
  assign pc_d = flush ? bus.redirect_pc : pc_inc ? pc_q + DATA_BITS'(4) : pc_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end
  // Inst and pc are stable for the whole burst, so tgt decodes live in either state.
  assign we            = (is_burst | busy) ? tgt_we(tgt) : acc_we_t'(4'b0000);
  assign bus.imem_addr = pc_q;
  assign bus.pc_out    = pc_q;
  assign bus.inst_out  = bus.imem_rdata;
  assign bus.ntt_we    = we.ntt;
  assign bus.pwam_wea  = we.pwam_a;
  assign bus.pwam_web  = we.pwam_b;
  assign bus.keccak_we = we.keccak;
  assign bus.counter   = busy ? DATA_BITS'(beat) : '0;
  assign bus.busy      = busy;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed fetch/burst sequences checked by a per-cycle scoreboard.
module tb_if_fetch_unit;
  typedef struct {
    logic [63:0] pc;
    logic [3:0]  we;
    logic [63:0] cnt;
    logic        busy;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] rom [0:127];
  exp_t        sb[$];
  exp_t        e;
  int          passed = 0;
  int          total = 0;
  if_fetch_unit_if bus();
  if_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.imem_rdata = rom[bus.imem_addr[8:2]];
  function automatic logic [31:0] acc(input logic [11:0] len, input logic [2:0] tgt);
    return {len, 5'd0, tgt, 5'd0, 7'h0B};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pc_out", bus.pc_out, e.pc);
      chk("imem_addr", bus.imem_addr, e.pc);
      chk("inst_out", 64'(bus.inst_out), 64'(rom[e.pc[8:2]]));
      chk("we", 64'({bus.keccak_we, bus.pwam_web, bus.pwam_wea, bus.ntt_we}), 64'(e.we));
      chk("counter", bus.counter, e.cnt);
      chk("busy", 64'(bus.busy), 64'(e.busy));
    end
  end
  task automatic step(input logic ce, input logic st, input logic rv, input logic [63:0] rpc,
                      input logic [63:0] epc, input logic [3:0] ewe, input logic [63:0] ecnt,
                      input logic ebusy);
    bus.CE = ce;
    bus.stall = st;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    sb.push_back('{pc: epc, we: ewe, cnt: ecnt, busy: ebusy});
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 32'h0000_0013;
    rom[4]  = acc(12'd3, 3'd3);
    rom[5]  = acc(12'd4, 3'd1);
    rom[6]  = acc(12'd5, 3'd0);
    rom[64] = acc(12'd0, 3'd0);
    rom[65] = acc(12'd2, 3'd5);
    rom[67] = acc(12'd1, 3'd2);
    bus.CE = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 64'h0, 4'h0, 0, 0);
    rst = 1'b1;
    step(1, 0, 0, 0, 64'h0, 4'h0, 0, 0);
    step(1, 0, 0, 0, 64'h4, 4'h0, 0, 0);
    step(1, 1, 0, 0, 64'h8, 4'h0, 0, 0);
    step(1, 1, 0, 0, 64'h8, 4'h0, 0, 0);
    step(1, 0, 0, 0, 64'h8, 4'h0, 0, 0);
    step(1, 0, 0, 0, 64'hC, 4'h0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 64'h10, 4'h8, 64'(i), i != 0);
    step(1, 0, 0, 0, 64'h14, 4'h2, 0, 0);
    step(1, 0, 0, 0, 64'h14, 4'h2, 1, 1);
    step(1, 1, 0, 0, 64'h14, 4'h2, 2, 1);
    step(1, 1, 0, 0, 64'h14, 4'h2, 2, 1);
    step(1, 0, 0, 0, 64'h14, 4'h2, 2, 1);
    step(1, 0, 0, 0, 64'h14, 4'h2, 3, 1);
    step(1, 0, 0, 0, 64'h18, 4'h1, 0, 0);
    step(1, 1, 1, 64'h100, 64'h18, 4'h1, 1, 1);
    step(1, 0, 0, 0, 64'h100, 4'h0, 0, 0);
    step(1, 0, 0, 0, 64'h104, 4'h0, 0, 0);
    step(0, 0, 0, 0, 64'h108, 4'h0, 0, 0);
    step(0, 0, 1, 64'h200, 64'h108, 4'h0, 0, 0);
    step(1, 0, 0, 0, 64'h108, 4'h0, 0, 0);
    step(1, 0, 0, 0, 64'h10C, 4'h4, 0, 0);
    step(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h110, 4'h0, 0, 0);
    step(1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 4'h0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 64'(4 * i), 4'h0, 0, 0);
    step(1, 0, 0, 0, 64'h10, 4'h8, 0, 0);
    rst = 1'b0;
    step(1, 0, 0, 0, 64'h0, 4'h0, 0, 0);
    rst = 1'b1;
    step(1, 0, 0, 0, 64'h0, 4'h0, 0, 0);
    step(1, 0, 0, 0, 64'h4, 4'h0, 0, 0);
    @(negedge clk);
    #1;
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
